// File: rtl/fillscreen_pkg.sv
// Shared screen geometry, bus widths and fill-engine state encoding.
package fillscreen_pkg;

   localparam int SCREEN_W = 160;
   localparam int SCREEN_H = 120;
   localparam int X_W      = 8;
   localparam int Y_W      = 7;
   localparam int COLOUR_W = 3;

   // Last column/row indices, sized to the counters they are compared with.
   localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
   localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

   typedef enum logic [1:0] {
      IDLE,
      FILL,
      DONE
   } state_t;

   // Stripe colour of a column: the low bits of x, i.e. x mod 8.
   function automatic logic [COLOUR_W-1:0] colour_of(input logic [X_W-1:0] x);
      return x[COLOUR_W-1:0];
   endfunction

endpackage

// File: rtl/fillscreen_if.sv
// Pixel-write bus between the fill engine and its consumers.
interface fillscreen_if;
   import fillscreen_pkg::*;

   logic [X_W-1:0]      x;
   logic [Y_W-1:0]      y;
   logic [COLOUR_W-1:0] colour;
   logic                plot;

   modport master (output x, output y, output colour, output plot);
   modport slave  (input  x, input  y, input  colour, input  plot);

endinterface

// File: rtl/fillscreen.sv
// Fill engine: writes every pixel of the screen once, column-major, with
// colour = x mod 8, then parks in DONE until the next reset.
module fillscreen
   import fillscreen_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   output logic         done,
   fillscreen_if.master pix
);

   state_t         state_q, state_d;
   logic [X_W-1:0] x_q, x_d;
   logic [Y_W-1:0] y_q, y_d;

   // State and pixel counters; reset forces IDLE at (0,0) immediately.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= '0;
         y_q     <= '0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
      end
   end

   // Next state and counter advance: y runs fastest, x steps at the bottom row.
   always_comb begin
      // NOTE: defaults first, so no path through this block leaves a variable unassigned (no latch).
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = FILL;
               x_d     = '0;
               y_d     = '0;
            end
         end
         FILL: begin
            if (y_q == Y_LAST) begin
               if (x_q == X_LAST) begin
                  // Final pixel is on the bus this cycle; counters hold it.
                  state_d = DONE;
               end else begin
                  y_d = '0;
                  x_d = x_q + 1'b1;
               end
            end else begin
               y_d = y_q + 1'b1;
            end
         end
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   // Bus and status outputs decoded purely from the registered state.
   always_comb begin
      pix.x      = x_q;
      pix.y      = y_q;
      pix.colour = colour_of(x_q);
      pix.plot   = (state_q == FILL);
      done       = (state_q == DONE);
   end

endmodule

// File: rtl/vga_adapter.sv
// Port-compatible stand-in for the codebase VGA adapter core: a 160x120x3
// framebuffer written from the pixel bus and scanned out at 640x480 with
// each framebuffer pixel covering a 4x4 block.
module vga_adapter (
   input  logic       resetn,
   input  logic       clock,
   input  logic [2:0] colour,
   input  logic [7:0] x,
   input  logic [6:0] y,
   input  logic       plot,
   output logic [7:0] VGA_R,
   output logic [7:0] VGA_G,
   output logic [7:0] VGA_B,
   output logic       VGA_HS,
   output logic       VGA_VS,
   output logic       VGA_CLK
);

   logic [2:0]  fb [0:19199];
   logic [14:0] wr_addr, rd_addr;
   logic        pix_en_q;
   logic [9:0]  h_q, v_q;
   logic        visible;
   logic [2:0]  pixel_q;

   assign wr_addr = 15'(y) * 15'd160 + 15'(x);
   assign rd_addr = 15'(v_q[8:2]) * 15'd160 + 15'(h_q[9:2]);
   assign visible = (h_q < 10'd640) && (v_q < 10'd480);

   // Framebuffer write port and registered scan-out read.
   // NOTE: the framebuffer has no reset; its contents are only meaningful once written.
   always_ff @(posedge clock) begin
      if (plot && (x < 8'd160) && (y < 7'd120)) begin
         fb[wr_addr] <= colour;
      end
      pixel_q <= visible ? fb[rd_addr] : 3'b000;
   end

   // Pixel-clock enable and 800x525 raster counters.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pix_en_q <= 1'b0;
         h_q      <= '0;
         v_q      <= '0;
      end else begin
         pix_en_q <= ~pix_en_q;
         if (pix_en_q) begin
            if (h_q == 10'd799) begin
               h_q <= '0;
               v_q <= (v_q == 10'd524) ? 10'd0 : v_q + 10'd1;
            end else begin
               h_q <= h_q + 10'd1;
            end
         end
      end
   end

   assign VGA_R   = {8{pixel_q[2]}};
   assign VGA_G   = {8{pixel_q[1]}};
   assign VGA_B   = {8{pixel_q[0]}};
   assign VGA_HS  = ~((h_q >= 10'd656) && (h_q < 10'd752));
   assign VGA_VS  = ~((v_q >= 10'd490) && (v_q < 10'd492));
   assign VGA_CLK = pix_en_q;

endmodule

// File: rtl/task2_fillscreen.sv
// Board top: runs the fill engine once per KEY[3] release and feeds its
// pixel bus to both the VGA_* pins and the VGA adapter.
module task2_fillscreen
   import fillscreen_pkg::*;
(
   input  logic                CLOCK_50,
   input  logic [3:0]          KEY,
   input  logic [9:0]          SW,
   output logic [9:0]          LEDR,
   output logic [6:0]          HEX0,
   output logic [6:0]          HEX1,
   output logic [6:0]          HEX2,
   output logic [6:0]          HEX3,
   output logic [6:0]          HEX4,
   output logic [6:0]          HEX5,
   output logic [7:0]          VGA_R,
   output logic [7:0]          VGA_G,
   output logic [7:0]          VGA_B,
   output logic                VGA_HS,
   output logic                VGA_VS,
   output logic                VGA_CLK,
   output logic [X_W-1:0]      VGA_X,
   output logic [Y_W-1:0]      VGA_Y,
   output logic [COLOUR_W-1:0] VGA_COLOUR,
   output logic                VGA_PLOT
);

   logic rst;
   logic rst_n;
   logic fill_done;
   logic unused_inputs;

   fillscreen_if pix ();

   assign rst           = KEY[3];
   assign rst_n         = ~KEY[3];
   assign unused_inputs = ^{SW, KEY[2:0]};

   fillscreen u_fill (
      .clk   (CLOCK_50),
      .rst   (rst),
      .start (1'b1),
      .done  (fill_done),
      .pix   (pix)
   );

   assign VGA_X      = pix.x;
   assign VGA_Y      = pix.y;
   assign VGA_COLOUR = pix.colour;
   assign VGA_PLOT   = pix.plot;

   assign LEDR = {9'b0, fill_done};
   assign HEX0 = 7'h7F;
   assign HEX1 = 7'h7F;
   assign HEX2 = 7'h7F;
   assign HEX3 = 7'h7F;
   assign HEX4 = 7'h7F;
   assign HEX5 = 7'h7F;

   vga_adapter u_vga (
      .resetn  (rst_n),
      .clock   (CLOCK_50),
      .colour  (pix.colour),
      .x       (pix.x),
      .y       (pix.y),
      .plot    (pix.plot),
      .VGA_R   (VGA_R),
      .VGA_G   (VGA_G),
      .VGA_B   (VGA_B),
      .VGA_HS  (VGA_HS),
      .VGA_VS  (VGA_VS),
      .VGA_CLK (VGA_CLK)
   );

endmodule

// File: tb/tb_task2_fillscreen.sv
// Bench for task2_fillscreen: pixel sequence against an arithmetic model,
// plotted-pixel scoreboard, completion, and resets from several points.
module tb_task2_fillscreen;
   import fillscreen_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [3:0]          KEY;
   logic [9:0]          SW;
   logic [9:0]          LEDR;
   logic [6:0]          HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
   logic [7:0]          VGA_R, VGA_G, VGA_B;
   logic                VGA_HS, VGA_VS, VGA_CLK;
   logic [X_W-1:0]      VGA_X;
   logic [Y_W-1:0]      VGA_Y;
   logic [COLOUR_W-1:0] VGA_COLOUR;
   logic                VGA_PLOT;

   task2_fillscreen dut (
      .CLOCK_50   (clk),
      .KEY        (KEY),
      .SW         (SW),
      .LEDR       (LEDR),
      .HEX0       (HEX0),
      .HEX1       (HEX1),
      .HEX2       (HEX2),
      .HEX3       (HEX3),
      .HEX4       (HEX4),
      .HEX5       (HEX5),
      .VGA_R      (VGA_R),
      .VGA_G      (VGA_G),
      .VGA_B      (VGA_B),
      .VGA_HS     (VGA_HS),
      .VGA_VS     (VGA_VS),
      .VGA_CLK    (VGA_CLK),
      .VGA_X      (VGA_X),
      .VGA_Y      (VGA_Y),
      .VGA_COLOUR (VGA_COLOUR),
      .VGA_PLOT   (VGA_PLOT)
   );

   // Monitor bundle carrying the observed pixel bus.
   fillscreen_if mon ();
   assign mon.x      = VGA_X;
   assign mon.y      = VGA_Y;
   assign mon.colour = VGA_COLOUR;
   assign mon.plot   = VGA_PLOT;

   int total = 0;
   int bad   = 0;

   bit seen [SCREEN_W][SCREEN_H];
   int uniq, plotted, colour_err, range_err;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: the n-th FILL cycle (1-based) shows column (n-1)/H, row (n-1)%H.
   function automatic logic [63:0] model_pix(input int n);
      int mx, my;
      mx = (n - 1) / SCREEN_H;
      my = (n - 1) % SCREEN_H;
      return {45'b0, 8'(mx), 7'(my), 3'(mx % 8), 1'b1};
   endfunction

   function automatic logic [63:0] bus();
      return {45'b0, mon.x, mon.y, mon.colour, mon.plot};
   endfunction

   task automatic clear_sb();
      for (int i = 0; i < SCREEN_W; i++)
         for (int j = 0; j < SCREEN_H; j++)
            seen[i][j] = 1'b0;
      uniq = 0; plotted = 0; colour_err = 0; range_err = 0;
   endtask

   task automatic record();
      if (mon.plot === 1'b1) begin
         plotted++;
         if (int'(mon.x) >= SCREEN_W || int'(mon.y) >= SCREEN_H) begin
            range_err++;
         end else begin
            if (!seen[mon.x][mon.y]) begin
               seen[mon.x][mon.y] = 1'b1;
               uniq++;
            end
            if (int'(mon.colour) != int'(mon.x) % 8) colour_err++;
         end
      end
   endtask

   // Runs FILL cycles first..last (1-based), checking each against the model.
   task automatic run_cycles(input int first, input int last);
      for (int n = first; n <= last; n++) begin
         @(negedge clk);
         if (n % 97 == 0) begin
            KEY[2:0] = 3'($urandom);
            SW       = 10'($urandom);
         end
         record();
         check($sformatf("pix_c%0d", n), bus(), model_pix(n));
      end
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, "_plot"}, 64'(VGA_PLOT), 64'd0);
      check({tag, "_x"}, 64'(VGA_X), 64'd0);
      check({tag, "_y"}, 64'(VGA_Y), 64'd0);
      check({tag, "_colour"}, 64'(VGA_COLOUR), 64'd0);
      check({tag, "_ledr"}, 64'(LEDR), 64'd0);
      check({tag, "_hex"}, 64'({HEX0, HEX1, HEX2, HEX3, HEX4, HEX5}), {22'b0, {42{1'b1}}});
   endtask

   task automatic check_done(input string tag, input int hold);
      @(negedge clk);
      check({tag, "_plot_fall"}, 64'(VGA_PLOT), 64'd0);
      check({tag, "_ledr_rise"}, 64'(LEDR), 64'd1);
      check({tag, "_last_xyc"}, 64'({VGA_X, VGA_Y, VGA_COLOUR}), 64'({8'd159, 7'd119, 3'd7}));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         record();
         check({tag, "_hold"}, 64'({VGA_PLOT, LEDR, VGA_X, VGA_Y}), 64'({1'b0, 10'd1, 8'd159, 7'd119}));
      end
   endtask

   task automatic check_scoreboard(input string tag);
      check({tag, "_unique"}, 64'(uniq), 64'd19200);
      check({tag, "_plotted"}, 64'(plotted), 64'd19200);
      check({tag, "_colour_err"}, 64'(colour_err), 64'd0);
      check({tag, "_range_err"}, 64'(range_err), 64'd0);
   endtask

   initial begin
      int cut, hold;
      KEY = {1'b1, 3'($urandom)};
      SW  = 10'($urandom);

      // Reset held across edges: nothing plotted.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("rst_hold_plot", 64'(VGA_PLOT), 64'd0);
      end
      check_reset_vals("rst");

      // Full fill from reset release.
      KEY[3] = 1'b0;
      clear_sb();
      run_cycles(1, 19200);
      check_done("fill1", 1000);
      check_scoreboard("sb1");

      // Reset from DONE is asynchronous.
      KEY[3] = 1'b1;
      #1;
      check_reset_vals("rst_done");
      repeat (3) @(negedge clk);
      check("rst_done_plot", 64'(VGA_PLOT), 64'd0);

      // Reset mid-fill at cycle 5000, then a full restart.
      KEY[3] = 1'b0;
      run_cycles(1, 5000);
      KEY[3] = 1'b1;
      #1;
      check_reset_vals("rst_mid");
      hold = $urandom_range(1, 5);
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check("rst_mid_hold_plot", 64'(VGA_PLOT), 64'd0);
      end
      KEY[3] = 1'b0;
      clear_sb();
      run_cycles(1, 19200);
      check_done("fill2", 20);
      check_scoreboard("sb2");

      // Reset at a random point of a fill, then check the restart.
      cut = $urandom_range(2, 19199);
      KEY[3] = 1'b1;
      @(negedge clk);
      KEY[3] = 1'b0;
      run_cycles(1, cut);
      KEY[3] = 1'b1;
      #1;
      check_reset_vals("rst_rand");
      @(negedge clk);
      KEY[3] = 1'b0;
      run_cycles(1, 300);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/task2_fillscreen.md
# task2_fillscreen

Top-level lab block that fills the 160×120 VGA framebuffer with vertical colour stripes after reset. It sits directly under the board pins: CLOCK_50, KEY, SW, LEDR, HEX and VGA. It contains a pixel-fill engine that drives the pixel-write bus (VGA_X/Y/COLOUR/PLOT). That bus is also fed into the codebase's existing vga_adapter instance, which generates the analog-side VGA signals.

## Interface
- No parameters; screen geometry constants come from the shared package.
- CLOCK_50  in  1  system clock, all logic on rising edge.
- KEY  in  4  KEY[3] = reset, asynchronous, active-high; KEY[2:0] unused.
- SW  in  10  unused.
- LEDR  out  10  LEDR[0] = fill done; LEDR[9:1] = 0.
- HEX0..HEX5  out  7 each  all segments off (7'h7F).
- VGA_R, VGA_G, VGA_B  out  8 each  from vga_adapter.
- VGA_HS, VGA_VS, VGA_CLK  out  1 each  from vga_adapter.
- VGA_X  out  8  pixel column, 0..159.
- VGA_Y  out  7  pixel row, 0..119.
- VGA_COLOUR  out  3  pixel colour.
- VGA_PLOT  out  1  write strobe; one pixel is written per cycle while high.

## Operation
- The fill engine FSM has three states: IDLE, FILL, DONE.
- **IDLE**
  - Entered while reset is asserted.
  - x=0, y=0, VGA_PLOT=0, done=0.
  - On the first clock edge after reset deasserts, the FSM moves to FILL.
- **FILL**
  - Each cycle presents VGA_X=x, VGA_Y=y, VGA_COLOUR=x[2:0] (x mod 8), VGA_PLOT=1.
  - Order is column-major: y increments first.
  - When y=119: y←0 and x←x+1.
  - When x=159 and y=119 the final pixel is plotted and the next state is DONE.
- **DONE**
  - VGA_PLOT=0, done=1; VGA_X/Y/COLOUR hold their last values.
  - The FSM stays here until reset; the fill runs exactly once per reset release.
- Counter widths: x is 8 bits, y is 7 bits, compared against 159/119. No wrap past these bounds is ever presented on the bus.
- vga_adapter is the existing core and is not reimplemented here.
  - Its clock is CLOCK_50.
  - Its reset is the internal active-low reset ~KEY[3].
  - Its x/y/colour/plot inputs are tied to VGA_X/Y/COLOUR/PLOT.

## Timing
- Reset values: VGA_PLOT=0, VGA_X=0, VGA_Y=0, VGA_COLOUR=0, LEDR=0, HEX=7'h7F.
- VGA_X/Y/COLOUR/PLOT and done are registered (no combinational path from KEY).
- Edge 1 after reset release: FSM enters FILL; pixel (0,0) colour 0 is on the bus with PLOT=1 for that cycle.
- Cycle n (1-based) of FILL presents pixel x=(n-1)/120, y=(n-1)%120.
- The FILL phase lasts exactly 19200 cycles. On edge 19201, PLOT falls to 0 and LEDR[0] rises to 1.
- Reset asserted at any time, including mid-fill, forces IDLE values asynchronously. On release the fill restarts from (0,0).
- Reset held across a clock edge produces no plot.

## Structure
- Package fillscreen_pkg holds:
  - SCREEN_W=160 and SCREEN_H=120;
  - X_W=8, Y_W=7 and COLOUR_W=3;
  - the FSM state enum {IDLE, FILL, DONE}.
- Sub-module fillscreen, which contains the FSM and counters.
  - Ports: clk, rst (async active-high), start, done, vga_x, vga_y, vga_colour, vga_plot.
  - task2_fillscreen ties start=1 and maps KEY[3] to rst.
  - fillscreen begins FILL on the first edge with start=1 in IDLE.
- The top level only wires pins, drives the constant LEDR/HEX values and instantiates vga_adapter.

## Test plan
- **Reset values.** KEY[3]=1 for 10 cycles -> VGA_PLOT=0, VGA_X=0, VGA_Y=0, LEDR=0, all HEX=7'h7F.
- **First pixels.** Release reset -> next cycle (0,0,c0,PLOT=1), then (0,1,c0). Cycle 120 is (0,119,c0); cycle 121 is (1,0,c1).
- **Colour wrap.** Cycle 961 presents x=8, y=0, colour 0. Cycle 1081 presents x=9, colour 1.
- **Completion.** Cycle 19200 presents (159,119, colour 7, PLOT=1). Cycle 19201 gives PLOT=0 and LEDR[0]=1, held for ≥1000 further cycles.
- **Reset mid-fill.** Assert KEY[3] at cycle 5000 -> PLOT drops immediately and outputs return to reset values. After release, the fill restarts at (0,0) and completes 19200 cycles later.
- **Scoreboard.** Record all plotted (x,y) pairs -> exactly 19200 unique pairs, each with colour == x%8, and none outside 160×120.
